// File: rtl/pwr_seq_arbiter.sv
// Round-robin power-gating sequencer: orders iso/ret/pse per domain,
// one domain at a time, with settle delays and ack timeouts.
module pwr_seq_arbiter #(
  parameter int NUM_DOM     = 2,
  parameter int STEP_DLY    = 2,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_DOM-1:0] pwr_sig,
  input  logic [NUM_DOM-1:0] pse_ack,
  output logic [NUM_DOM-1:0] pse,
  output logic [NUM_DOM-1:0] iso,
  output logic [NUM_DOM-1:0] ret,
  output logic [NUM_DOM-1:0] dom_off,
  output logic               busy,
  output logic [2:0]         act_dom,
  output logic [NUM_DOM-1:0] err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISO_ON,
    S_RET_ON,
    S_PSE_OFF,
    S_DONE,
    S_PSE_ON,
    S_RET_OFF
  } state_t;

  state_t state, state_n;

  logic [3:0]         step_cnt, step_n;
  logic [7:0]         ack_cnt, ack_n;
  logic [2:0]         ptr, ptr_n;
  logic [2:0]         act_n;
  logic [NUM_DOM-1:0] pse_n, iso_n, ret_n, off_n, err_n;
  logic               busy_n;

  logic [NUM_DOM-1:0] pending, sel, gsel;
  logic [2:0]         gnt, gnt_hi, gnt_lo, ptr_nxt;
  logic               gnt_ok, hi_ok, lo_ok;
  logic               step_end, ack_up, ack_to;
  logic [3:0]         step_inc;
  logic [7:0]         ack_inc;

  assign pending = pwr_sig ^ dom_off;
  assign sel     = NUM_DOM'(1) << act_dom;
  assign gsel    = NUM_DOM'(1) << gnt;
  assign ptr_nxt = (act_dom == 3'(NUM_DOM - 1)) ? 3'd0 : act_dom + 3'd1;

  // first pending index at/after ptr, else lowest pending (wrap)
  always_comb begin
    hi_ok  = 1'b0;
    lo_ok  = 1'b0;
    gnt_hi = '0;
    gnt_lo = '0;
    for (int i = NUM_DOM - 1; i >= 0; i--) begin
      if (pending[i]) begin
        if (3'(i) >= ptr) begin
          hi_ok  = 1'b1;
          gnt_hi = 3'(i);
        end
        lo_ok  = 1'b1;
        gnt_lo = 3'(i);
      end
    end
    gnt_ok = hi_ok | lo_ok;
    gnt    = hi_ok ? gnt_hi : gnt_lo;
  end

  assign step_end = (step_cnt == 4'(STEP_DLY - 1));
  assign step_inc = (step_cnt == 4'hf) ? step_cnt : step_cnt + 4'd1;
  assign ack_up   = |(pse_ack & sel);
  assign ack_to   = (ack_cnt == 8'(ACK_TIMEOUT - 1));
  assign ack_inc  = (ack_cnt == 8'hff) ? ack_cnt : ack_cnt + 8'd1;

  always_comb begin
    state_n = state;
    step_n  = step_cnt;
    ack_n   = ack_cnt;
    ptr_n   = ptr;
    act_n   = act_dom;
    pse_n   = pse;
    iso_n   = iso;
    ret_n   = ret;
    off_n   = dom_off;
    err_n   = err;
    busy_n  = busy;
    unique case (state)
      S_IDLE: begin
        if (gnt_ok) begin
          act_n  = gnt;
          busy_n = 1'b1;
          step_n = '0;
          ack_n  = '0;
          if (|(pwr_sig & gsel)) begin
            state_n = S_ISO_ON;
            iso_n   = iso | gsel;
          end else begin
            state_n = S_PSE_ON;
            pse_n   = pse | gsel;
          end
        end
      end
      S_ISO_ON: begin
        if (step_end) begin
          state_n = S_RET_ON;
          step_n  = '0;
          ret_n   = ret | sel;
        end else begin
          step_n = step_inc;
        end
      end
      S_RET_ON: begin
        if (step_end) begin
          state_n = S_PSE_OFF;
          step_n  = '0;
          ack_n   = '0;
          pse_n   = pse & ~sel;
        end else begin
          step_n = step_inc;
        end
      end
      S_PSE_OFF: begin
        if (!ack_up) begin
          state_n = S_DONE;
        end else if (ack_to) begin
          state_n = S_DONE;
          err_n   = err | sel;
        end else begin
          ack_n = ack_inc;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        off_n   = dom_off | sel;
        busy_n  = 1'b0;
        ptr_n   = ptr_nxt;
      end
      S_PSE_ON: begin
        if (ack_up || ack_to) begin
          state_n = S_RET_OFF;
          step_n  = '0;
          ret_n   = ret & ~sel;
          if (!ack_up) err_n = err | sel;
        end else begin
          ack_n = ack_inc;
        end
      end
      S_RET_OFF: begin
        if (step_end) begin
          state_n = S_IDLE;
          iso_n   = iso & ~sel;
          off_n   = dom_off & ~sel;
          busy_n  = 1'b0;
          ptr_n   = ptr_nxt;
        end else begin
          step_n = step_inc;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      step_cnt <= '0;
      ack_cnt  <= '0;
      ptr      <= '0;
      act_dom  <= '0;
      pse      <= '1;
      iso      <= '0;
      ret      <= '0;
      dom_off  <= '0;
      err      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      step_cnt <= step_n;
      ack_cnt  <= ack_n;
      ptr      <= ptr_n;
      act_dom  <= act_n;
      pse      <= pse_n;
      iso      <= iso_n;
      ret      <= ret_n;
      dom_off  <= off_n;
      err      <= err_n;
      busy     <= busy_n;
    end
  end

`ifndef SYNTHESIS
  // reset is a forced POR exit, so ordering is only checked outside it
  for (genvar d = 0; d < NUM_DOM; d++) begin : g_ord
    a_iso_rise: assert property (@(posedge clk) disable iff (reset)
      !$past(reset) && $rose(iso[d]) |->
        pse[d] && !ret[d] && $stable(pse[d]) && $stable(ret[d]));
    a_ret_rise: assert property (@(posedge clk) disable iff (reset)
      !$past(reset) && $rose(ret[d]) |->
        pse[d] && iso[d] && $stable(pse[d]) && $stable(iso[d]));
    a_pse_fall: assert property (@(posedge clk) disable iff (reset)
      !$past(reset) && $fell(pse[d]) |->
        iso[d] && ret[d] && $stable(iso[d]) && $stable(ret[d]));
    a_pse_rise: assert property (@(posedge clk) disable iff (reset)
      !$past(reset) && $rose(pse[d]) |->
        iso[d] && ret[d] && $stable(iso[d]) && $stable(ret[d]));
    a_ret_fall: assert property (@(posedge clk) disable iff (reset)
      !$past(reset) && $fell(ret[d]) |->
        pse[d] && iso[d] && $stable(pse[d]) && $stable(iso[d]));
    a_iso_fall: assert property (@(posedge clk) disable iff (reset)
      !$past(reset) && $fell(iso[d]) |->
        pse[d] && !ret[d] && $stable(pse[d]) && $stable(ret[d]));
  end
`endif

endmodule

// File: tb/tb_pwr_seq_arbiter.sv
// Directed bench for pwr_seq_arbiter: edge-exact checks of sequencing,
// round-robin, ack timeout and mid-sequence reset.
module tb_pwr_seq_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] pwr_sig = 2'b00;
  logic [1:0] pse_ack;
  logic [1:0] pse, iso, ret, dom_off, err;
  logic       busy;
  logic [2:0] act_dom;

  logic [1:0] ack_q = 2'b11;
  logic [1:0] stuck_hi = 2'b00;
  logic [13:0] exp_v;
  int n_run = 0;
  int n_fail = 0;

  pwr_seq_arbiter #(.NUM_DOM(2), .STEP_DLY(2), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .pwr_sig(pwr_sig), .pse_ack(pse_ack),
    .pse(pse), .iso(iso), .ret(ret), .dom_off(dom_off),
    .busy(busy), .act_dom(act_dom), .err(err)
  );

  always #5 clk = ~clk;

  // rail model: ack follows the switch enable one cycle late
  always @(posedge clk) ack_q <= pse;
  assign pse_ack = ack_q | stuck_hi;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [13:0] snap();
    return {pse, iso, ret, dom_off, err, busy, act_dom};
  endfunction

  function automatic logic [13:0] mk(input logic [1:0] p, input logic [1:0] i,
                                     input logic [1:0] r, input logic [1:0] o,
                                     input logic [1:0] e, input logic b,
                                     input logic [2:0] a);
    return {p, i, r, o, e, b, a};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    pwr_sig = 2'b11;
    tick(2);
    exp_v = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_vals got=%b exp=%b", snap(), exp_v);
    end
  endtask

  // pwr_sig=11 held through reset: dom0 then dom1, one idle cycle between
  task automatic test_back_to_back();
    reset = 1'b0;
    tick(1);
    exp_v = mk(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_e1 got=%b exp=%b", snap(), exp_v);
    end
    tick(7);
    exp_v = mk(2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_e8_idle got=%b exp=%b", snap(), exp_v);
    end
    tick(1);
    exp_v = mk(2'b10, 2'b11, 2'b01, 2'b01, 2'b00, 1'b1, 3'd1);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_e9_grant1 got=%b exp=%b", snap(), exp_v);
    end
    tick(6);
    exp_v = mk(2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 1'b1, 3'd1);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_e15 got=%b exp=%b", snap(), exp_v);
    end
    tick(1);
    exp_v = mk(2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0, 3'd1);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_e16_done got=%b exp=%b", snap(), exp_v);
    end
  endtask

  task automatic test_power_down();
    reset = 1'b1;
    pwr_sig = 2'b00;
    tick(2);
    reset = 1'b0;
    tick(1);
    pwr_sig = 2'b01;
    tick(1);
    exp_v = mk(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL dn_e1_iso got=%b exp=%b", snap(), exp_v);
    end
    tick(1);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL dn_e2_hold got=%b exp=%b", snap(), exp_v);
    end
    tick(1);
    exp_v = mk(2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL dn_e3_ret got=%b exp=%b", snap(), exp_v);
    end
    tick(2);
    exp_v = mk(2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL dn_e5_pse got=%b exp=%b", snap(), exp_v);
    end
    tick(2);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL dn_e7_wait got=%b exp=%b", snap(), exp_v);
    end
    tick(1);
    exp_v = mk(2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL dn_e8_off got=%b exp=%b", snap(), exp_v);
    end
  endtask

  task automatic test_power_up();
    pwr_sig = 2'b00;
    tick(1);
    exp_v = mk(2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL up_g_pse got=%b exp=%b", snap(), exp_v);
    end
    tick(1);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL up_g1_wait got=%b exp=%b", snap(), exp_v);
    end
    tick(1);
    exp_v = mk(2'b11, 2'b01, 2'b00, 2'b01, 2'b00, 1'b1, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL up_g2_ret got=%b exp=%b", snap(), exp_v);
    end
    tick(1);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL up_g3_hold got=%b exp=%b", snap(), exp_v);
    end
    tick(1);
    exp_v = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL up_g4_iso got=%b exp=%b", snap(), exp_v);
    end
  endtask

  task automatic test_ack_timeout();
    reset = 1'b1;
    pwr_sig = 2'b00;
    tick(2);
    reset = 1'b0;
    stuck_hi = 2'b10;
    pwr_sig = 2'b10;
    tick(1);
    exp_v = mk(2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 3'd1);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL to_e1_grant got=%b exp=%b", snap(), exp_v);
    end
    tick(11);
    exp_v = mk(2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 1'b1, 3'd1);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL to_e12_noerr got=%b exp=%b", snap(), exp_v);
    end
    tick(1);
    exp_v = mk(2'b01, 2'b10, 2'b10, 2'b00, 2'b10, 1'b1, 3'd1);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL to_e13_err got=%b exp=%b", snap(), exp_v);
    end
    tick(1);
    exp_v = mk(2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 3'd1);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL to_e14_off got=%b exp=%b", snap(), exp_v);
    end
    tick(5);
    n_run++;
    if (err !== 2'b10) begin
      n_fail++;
      $display("FAIL to_sticky got=%b exp=%b", err, 2'b10);
    end
    stuck_hi = 2'b00;
  endtask

  task automatic test_mid_reset();
    pwr_sig = 2'b11;
    tick(3);
    exp_v = mk(2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 1'b1, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL mr_e3_ret got=%b exp=%b", snap(), exp_v);
    end
    reset = 1'b1;
    pwr_sig = 2'b00;
    tick(1);
    exp_v = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL mr_forced got=%b exp=%b", snap(), exp_v);
    end
    reset = 1'b0;
    tick(3);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL mr_quiet got=%b exp=%b", snap(), exp_v);
    end
  endtask

  task automatic test_toggle_mid();
    pwr_sig = 2'b01;
    tick(1);
    pwr_sig = 2'b00;
    tick(7);
    exp_v = mk(2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL tg_e8_off got=%b exp=%b", snap(), exp_v);
    end
    tick(1);
    exp_v = mk(2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL tg_e9_regrant got=%b exp=%b", snap(), exp_v);
    end
    tick(4);
    exp_v = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL tg_e13_on got=%b exp=%b", snap(), exp_v);
    end
  endtask

  // pointer sits at 1 after serving dom0, so dom1 wins a tie
  task automatic test_round_robin();
    pwr_sig = 2'b11;
    tick(1);
    exp_v = mk(2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 3'd1);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL rr_first got=%b exp=%b", snap(), exp_v);
    end
    tick(8);
    exp_v = mk(2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 1'b1, 3'd0);
    n_run++;
    if (snap() !== exp_v) begin
      n_fail++;
      $display("FAIL rr_second got=%b exp=%b", snap(), exp_v);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_back_to_back();
    test_power_down();
    test_power_up();
    test_ack_timeout();
    test_mid_reset();
    test_toggle_mid();
    test_round_robin();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
